// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter and the two-digit BCD adder.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    // Double-dabble pre-shift correction: digits of 5 or more get 3 added.
    localparam bcd_digit_t ADJ_THRESHOLD = 4'd5;
    localparam bcd_digit_t ADJ_ADD       = 4'd3;

    // Decimal correction applied by the BCD adder after a binary digit add.
    localparam bcd_digit_t BCD_CORR      = 4'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 correction stage (purely combinational).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adj_digit
);

    // Add 3 to digits of 5 or more so the following left shift carries into the next digit.
    always_comb begin
        if (digit >= ADJ_THRESHOLD) begin
            adj_digit = digit + ADJ_ADD;
        end else begin
            adj_digit = digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter, one double-dabble iteration per clock,
// with valid/ready handshakes on input and output.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 64'sd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'sd10;
        end
        return p;
    endfunction

    // The digit count must be able to hold the largest binary input.
    if (pow10(DIGITS) <= ((64'sd1 <<< BIN_W) - 64'sd1)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   bin_r;
    logic [BCD_W-1:0]   bcd_sh_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   shift_bcd_s;
    logic [BIN_W-1:0]   shift_bin_s;
    logic               last_iter_s;
    logic               ovf_next_s;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (bcd_sh_r[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .adj_digit (adj_s[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Corrected BCD field and binary field shift left together as one register.
    assign {shift_bcd_s, shift_bin_s} = {adj_s, bin_r} << 1;
    assign last_iter_s = (cnt_r == CNT_W'(BIN_W - 1));

    // Anything in the hundreds digit or above cannot go to the two-digit adder.
    if (DIGITS > 2) begin : g_ovf
        assign ovf_next_s = |shift_bcd_s[BCD_W-1:2*BCD_DIGIT_W];
    end else begin : g_no_ovf
        assign ovf_next_s = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: accept in IDLE, iterate BIN_W times, hold result until consumed.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_iter_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, shift-and-add-3 while converting, capture result on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            bin_r    <= {BIN_W{1'b0}};
            bcd_sh_r <= {BCD_W{1'b0}};
            bcd_r    <= {BCD_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bin_r    <= in_bin;
                        bcd_sh_r <= {BCD_W{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        bin_r    <= bin_r;
                    end
                end
                SHIFT: begin
                    bcd_sh_r <= shift_bcd_s;
                    bin_r    <= shift_bin_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        bcd_r <= shift_bcd_s;
                        ovf_r <= ovf_next_s;
                    end else begin
                        bcd_r <= bcd_r;
                    end
                end
                DONE: begin
                    bcd_r <= bcd_r;
                end
                default: begin
                    bcd_r <= bcd_r;
                end
            endcase
        end
    end

    // Handshake flags decode from the state register only.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bcd       = bcd_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq with a scoreboard of expected {ovf, bcd} results.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        ovf;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [12:0] sb[$];

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference by decimal division: {ovf, hundreds, tens, ones}.
    function automatic logic [12:0] model(input int v);
        int h;
        int t;
        int o;
        logic [12:0] r;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        r[3:0]  = o[3:0];
        r[7:4]  = t[3:0];
        r[11:8] = h[3:0];
        r[12]   = (v > 99);
        return r;
    endfunction

    // Present one value for one clock edge (caller ensures in_ready) and log its expected result.
    task automatic send(input int v);
        in_bin   = v[7:0];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sb.push_back(model(v));
    endtask

    // Wait (bounded) for out_valid; cycles counts negedges since the call.
    task automatic collect(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bin    = 8'd0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, ovf, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b bcd=%h want 1 0 0 000",
                     in_ready, out_valid, ovf, bcd);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        logic [12:0] exp;
        out_ready = 1'b1;
        send(17);
        collect(cyc);
        tests_run++;
        if (cyc !== 8) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles want 8", cyc);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
        tests_run++;
        if ({ovf, bcd} !== exp || exp !== 13'h0017) begin
            tests_failed++;
            $display("FAIL basic_result: got ovf=%b bcd=%h want %h", ovf, bcd, exp);
        end
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ready_after: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_boundaries();
        int vals[4] = '{0, 99, 100, 255};
        int cyc;
        logic [12:0] exp;
        out_ready = 1'b1;
        foreach (vals[k]) begin
            send(vals[k]);
            collect(cyc);
            exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
            tests_run++;
            if (out_valid !== 1'b1 || {ovf, bcd} !== exp) begin
                tests_failed++;
                $display("FAIL boundary_%0d: got vld=%b ovf=%b bcd=%h want ovf/bcd %h",
                         vals[k], out_valid, ovf, bcd, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep();
        int cyc;
        logic [12:0] exp;
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            send(v);
            collect(cyc);
            exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
            tests_run++;
            if (out_valid !== 1'b1 || cyc !== 8 || {ovf, bcd} !== exp) begin
                tests_failed++;
                $display("FAIL sweep_%0d: got vld=%b cyc=%0d ovf=%b bcd=%h want %h",
                         v, out_valid, cyc, ovf, bcd, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [12:0] exp;
        out_ready = 1'b0;
        send(62);
        collect(cyc);
        exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
        tests_run++;
        if (cyc !== 8 || {ovf, bcd} !== exp) begin
            tests_failed++;
            $display("FAIL bp_result: got cyc=%0d ovf=%b bcd=%h want 8 %h", cyc, ovf, bcd, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, bcd} !== 13'h0062) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b ovf=%b bcd=%h want 1 0 0 062",
                         i, out_valid, in_ready, ovf, bcd);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 12'h062) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy=%b vld=%b bcd=%h want 1 0 062",
                     in_ready, out_valid, bcd);
        end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        int stray;
        logic [12:0] exp;
        out_ready = 1'b1;
        send(24);
        in_bin   = 8'd200;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        in_bin   = 8'd0;
        collect(cyc);
        exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
        tests_run++;
        if (out_valid !== 1'b1 || cyc !== 4 || {ovf, bcd} !== exp) begin
            tests_failed++;
            $display("FAIL busy_result: got vld=%b cyc=%0d ovf=%b bcd=%h want cyc 4 %h",
                     out_valid, cyc, ovf, bcd, exp);
        end
        @(negedge clk);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1 || in_ready !== 1'b1) stray++;
            @(negedge clk);
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL busy_not_queued: got %0d busy cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stray;
        logic [12:0] exp;
        out_ready = 1'b1;
        send(98);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        tests_run++;
        if ({in_ready, out_valid, ovf, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            tests_failed++;
            $display("FAIL midreset_state: got rdy=%b vld=%b ovf=%b bcd=%h want 1 0 0 000",
                     in_ready, out_valid, ovf, bcd);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || bcd !== 12'h000) stray++;
            @(negedge clk);
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_partial: got %0d bad cycles want 0", stray);
        end
        send(98);
        collect(cyc);
        exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
        tests_run++;
        if (out_valid !== 1'b1 || {ovf, bcd} !== exp || exp !== 13'h0098) begin
            tests_failed++;
            $display("FAIL midreset_fresh: got vld=%b ovf=%b bcd=%h want %h",
                     out_valid, ovf, bcd, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{7, 42, 250};
        int idx;
        int nres;
        int last_cyc;
        bit acc;
        logic [12:0] exp;
        out_ready = 1'b1;
        idx       = 0;
        nres      = 0;
        last_cyc  = -1;
        in_bin    = vals[0][7:0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            acc = in_valid && in_ready;
            if (acc) sb.push_back(model(int'(in_bin)));
            if (out_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 13'bx;
                tests_run++;
                if ({ovf, bcd} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result_%0d: got ovf=%b bcd=%h want %h", nres, ovf, bcd, exp);
                end
                if (nres > 0) begin
                    tests_run++;
                    if (cyc - last_cyc !== 10) begin
                        tests_failed++;
                        $display("FAIL b2b_interval_%0d: got %0d cycles want 10", nres, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                nres++;
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) in_bin = vals[idx][7:0];
                else         in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (nres !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results want 3", nres);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_sweep();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
